tmr_apb_mc: RTL and testbench



---
 rtl/tmr_apb_mc_if.sv | 21 ++
 rtl/tmr_apb_mc.sv | 142 ++++++++++++++
 tb/tb_tmr_apb_mc.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/tmr_apb_mc_if.sv
// APB slave bus bundle for the multi-channel timer.
interface tmr_apb_mc_if;
    logic [7:0]  paddr;
    logic [31:0] prdata;
    logic [31:0] pwdata;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic        pready;
    logic        pslverr;

    modport master (
        output paddr, pwdata, psel, penable, pwrite,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, pwdata, psel, penable, pwrite,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/tmr_apb_mc.sv
// Multi-channel APB timer: shared prescaled up-counter, one-shot/auto-reload,
// internal or external tick source, ch_n compare channels with PWM and masked irq.
module tmr_apb_mc #(
    parameter int unsigned tmr_w = 16,
    parameter int unsigned pre_w = 8,
    parameter int unsigned ch_n  = 4
) (
    input  logic              pclk,
    input  logic              preset,
    tmr_apb_mc_if.slave       bus,
    output logic              irq,
    input  logic              tmr_in,
    output logic [ch_n-1:0]   tmr_out
);

    localparam logic [tmr_w-1:0] cnt_one = tmr_w'(1);
    localparam logic [pre_w-1:0] pre_one = pre_w'(1);
    localparam logic [5:0]       cmp_lo  = 6'd8;
    localparam logic [5:0]       cmp_hi  = 6'(8 + ch_n);

    logic             en, oneshot, ext;
    logic [pre_w-1:0] psc, pre_cnt;
    logic [tmr_w-1:0] load, cnt;
    logic [ch_n:0]    stat, mask;
    logic [tmr_w-1:0] cmp [ch_n];
    logic             s1, s2, s3;

    logic [5:0]       widx;
    logic             sel_ctrl, sel_load, sel_cnt, sel_stat, sel_mask, sel_cmp;
    logic             mapped, wr;
    logic [31:0]      rdata;
    logic             src, tick, wrap;
    logic [tmr_w-1:0] cnt_inc;
    logic [ch_n:0]    set, w1c;

    // Address decode and APB status
    always_comb begin
        widx     = bus.paddr[7:2];
        sel_ctrl = (widx == 6'd0);
        sel_load = (widx == 6'd1);
        sel_cnt  = (widx == 6'd2);
        sel_stat = (widx == 6'd3);
        sel_mask = (widx == 6'd4);
        sel_cmp  = (widx >= cmp_lo) && (widx < cmp_hi);
        mapped   = sel_ctrl | sel_load | sel_cnt | sel_stat | sel_mask | sel_cmp;
        wr       = bus.psel & bus.pwrite & bus.penable & mapped;
    end

    assign bus.pready  = bus.penable;
    assign bus.pslverr = bus.psel & bus.penable & ~mapped;
    assign bus.prdata  = rdata;

    always_comb begin
        rdata = '0;
        if (bus.psel && !bus.pwrite) begin
            if (sel_ctrl) begin
                rdata[0]          = en;
                rdata[1]          = oneshot;
                rdata[2]          = ext;
                rdata[8 +: pre_w] = psc;
            end
            if (sel_load) rdata[tmr_w-1:0] = load;
            if (sel_cnt)  rdata[tmr_w-1:0] = cnt;
            if (sel_stat) rdata[ch_n:0]    = stat;
            if (sel_mask) rdata[ch_n:0]    = mask;
            for (int unsigned i = 0; i < ch_n; i++) begin
                if (sel_cmp && widx[2:0] == 3'(i)) rdata[tmr_w-1:0] = cmp[i];
            end
        end
    end

    // Tick generation uses the CTRL value registered before this edge
    always_comb begin
        src     = ext ? (s2 & ~s3) : 1'b1;
        tick    = en & src & (pre_cnt == psc);
        wrap    = (cnt == load);
        cnt_inc = wrap ? '0 : cnt + cnt_one;
        set     = '0;
        set[0]  = tick & wrap;
        for (int unsigned i = 0; i < ch_n; i++) begin
            set[i+1] = tick & (cnt_inc == cmp[i]);
        end
        w1c = (wr && sel_stat) ? bus.pwdata[ch_n:0] : '0;
    end

    // Later assignments override earlier ones: register writes beat the timer update
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            en      <= 1'b0;
            oneshot <= 1'b0;
            ext     <= 1'b0;
            psc     <= '0;
            pre_cnt <= '0;
            load    <= '0;
            cnt     <= '0;
            stat    <= '0;
            mask    <= '0;
            s1      <= 1'b0;
            s2      <= 1'b0;
            s3      <= 1'b0;
            irq     <= 1'b0;
            tmr_out <= '0;
            for (int unsigned i = 0; i < ch_n; i++) cmp[i] <= '0;
        end else begin
            s1 <= tmr_in;
            s2 <= s1;
            s3 <= s2;

            if (en && src) pre_cnt <= (pre_cnt == psc) ? '0 : pre_cnt + pre_one;
            if (tick) begin
                cnt <= cnt_inc;
                if (wrap && oneshot) en <= 1'b0;
            end

            stat <= (stat & ~w1c) | set;
            irq  <= |(stat & mask);
            for (int unsigned i = 0; i < ch_n; i++) begin
                tmr_out[i] <= en & (cnt < cmp[i]);
            end

            if (wr) begin
                if (sel_ctrl) begin
                    en      <= bus.pwdata[0];
                    oneshot <= bus.pwdata[1];
                    ext     <= bus.pwdata[2];
                    psc     <= bus.pwdata[8 +: pre_w];
                    if (en && !bus.pwdata[0]) pre_cnt <= '0;
                end
                if (sel_load) load <= bus.pwdata[tmr_w-1:0];
                if (sel_cnt) begin
                    cnt     <= bus.pwdata[tmr_w-1:0];
                    pre_cnt <= '0;
                end
                if (sel_mask) mask <= bus.pwdata[ch_n:0];
                for (int unsigned i = 0; i < ch_n; i++) begin
                    if (sel_cmp && widx[2:0] == 3'(i)) cmp[i] <= bus.pwdata[tmr_w-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_tmr_apb_mc.sv
// Directed self-checking bench for tmr_apb_mc with hand-computed expectations.
module tb_tmr_apb_mc;

    logic       pclk = 1'b0;
    logic       preset = 1'b1;
    logic       irq;
    logic       tmr_in = 1'b0;
    logic [3:0] tmr_out;

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    tmr_apb_mc_if bus();

    tmr_apb_mc #(.tmr_w(16), .pre_w(8), .ch_n(4)) dut (
        .pclk    (pclk),
        .preset  (preset),
        .bus     (bus),
        .irq     (irq),
        .tmr_in  (tmr_in),
        .tmr_out (tmr_out)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 ns past the last one
    task automatic cyc(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    // Access phase (commit edge) lands on the 3rd rising edge after the call
    task automatic apb_wr(input logic [7:0] a, input logic [31:0] d);
        @(posedge pclk); #1;
        bus.psel = 1'b1; bus.pwrite = 1'b1; bus.penable = 1'b0;
        bus.paddr = a; bus.pwdata = d;
        @(posedge pclk); #1;
        bus.penable = 1'b1;
        @(posedge pclk); #1;
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    endtask

    // Samples state as it stands after the 2nd rising edge after the call
    task automatic apb_rd(input logic [7:0] a, output logic [31:0] d, output logic err);
        @(posedge pclk); #1;
        bus.psel = 1'b1; bus.pwrite = 1'b0; bus.penable = 1'b0; bus.paddr = a;
        @(posedge pclk); #1;
        bus.penable = 1'b1;
        #1;
        d   = bus.prdata;
        err = bus.pslverr;
        @(posedge pclk); #1;
        bus.psel = 1'b0; bus.penable = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic        e;
        apb_rd(a, d, e);
        chk(tag, d, exp);
    endtask

    task automatic do_reset();
        preset = 1'b1;
        cyc(2);
        preset = 1'b0;
        cyc(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic        e;
        int          hi0, hi1, hi2;

        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
        bus.paddr = '0; bus.pwdata = '0;

        // Reset state
        do_reset();
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_out", 32'(tmr_out), 32'd0);
        rd_chk("rst_ctrl", 8'h00, 32'd0);
        rd_chk("rst_load", 8'h04, 32'd0);
        rd_chk("rst_cnt",  8'h08, 32'd0);
        rd_chk("rst_stat", 8'h0C, 32'd0);
        rd_chk("rst_mask", 8'h10, 32'd0);
        rd_chk("rst_cmp3", 8'h2C, 32'd0);
        apb_rd(8'h00, d, e);
        chk("map_err", 32'(e), 32'd0);
        apb_rd(8'h40, d, e);
        chk("unmap_data", d, 32'd0);
        chk("unmap_err", 32'(e), 32'd1);
        apb_rd(8'h30, d, e);
        chk("cmp_oob_err", 32'(e), 32'd1);

        // Auto-reload, LOAD=9: wrap at E+10, irq at E+11
        apb_wr(8'h04, 32'd9);
        apb_wr(8'h10, 32'h1);
        apb_wr(8'h00, 32'h1);                  // commit edge E
        rd_chk("ar_cnt2", 8'h08, 32'd2);       // after E+2
        cyc(7);
        chk("ar_irq_pre", 32'(irq), 32'd0);    // after E+10
        cyc(1);
        chk("ar_irq_post", 32'(irq), 32'd1);   // after E+11
        rd_chk("ar_cnt_wrap", 8'h08, 32'd3);   // after E+13
        apb_wr(8'h0C, 32'h1);                  // W1C at E+17
        cyc(1);
        chk("ar_irq_clr", 32'(irq), 32'd0);    // after E+18
        cyc(3);
        chk("ar_irq_again", 32'(irq), 32'd1);  // after E+21
        preset = 1'b1;
        #2;
        chk("async_rst_irq", 32'(irq), 32'd0);
        cyc(1);
        preset = 1'b0;
        rd_chk("async_rst_ctrl", 8'h00, 32'd0);
        rd_chk("async_rst_stat", 8'h0C, 32'd0);

        // One-shot, LOAD=3, PSC=2: ticks at E+3,6,9; wrap and stop at E+12
        do_reset();
        apb_wr(8'h04, 32'd3);
        apb_wr(8'h00, 32'h0000_0203);
        rd_chk("os_cnt0", 8'h08, 32'd0);
        rd_chk("os_cnt1", 8'h08, 32'd1);
        rd_chk("os_cnt2", 8'h08, 32'd2);
        rd_chk("os_cnt3", 8'h08, 32'd3);
        rd_chk("os_ctrl", 8'h00, 32'h0000_0202);
        rd_chk("os_cnt_hold", 8'h08, 32'd0);
        rd_chk("os_stat", 8'h0C, 32'h1F);      // OVF plus MATCH on CMP=0
        apb_wr(8'h0C, 32'h1F);
        cyc(20);
        rd_chk("os_stat_once", 8'h0C, 32'd0);
        rd_chk("os_cnt_still", 8'h08, 32'd0);

        // PWM: LOAD=99, CMP0=25, CMP1=0, CMP2=200, MASK=MATCH0
        do_reset();
        apb_wr(8'h04, 32'd99);
        apb_wr(8'h20, 32'd25);
        apb_wr(8'h24, 32'd0);
        apb_wr(8'h28, 32'd200);
        apb_wr(8'h10, 32'h2);
        apb_wr(8'h00, 32'h1);                  // commit edge E
        hi0 = 0; hi1 = 0; hi2 = 0;
        for (int k = 1; k <= 100; k++) begin
            cyc(1);
            hi0 += int'(tmr_out[0]);
            hi1 += int'(tmr_out[1]);
            hi2 += int'(tmr_out[2]);
            if (k == 25) chk("pwm_irq_pre", 32'(irq), 32'd0);
            if (k == 26) chk("pwm_irq_post", 32'(irq), 32'd1);
        end
        chk("pwm_hi0", 32'(hi0), 32'd25);
        chk("pwm_hi1", 32'(hi1), 32'd0);
        chk("pwm_hi2", 32'(hi2), 32'd100);
        rd_chk("pwm_stat", 8'h0C, 32'h17);
        rd_chk("pwm_cmp2", 8'h28, 32'd200);

        // External source, PSC=1: tick 3 cycles after every second rising edge
        do_reset();
        apb_wr(8'h04, 32'd255);
        apb_wr(8'h20, 32'd1);
        apb_wr(8'h00, 32'h0000_0105);          // commit edge E = t0
        fork
            begin
                for (int p = 0; p < 6; p++) begin
                    tmr_in = 1'b1;
                    cyc(4);
                    tmr_in = 1'b0;
                    cyc(4);
                end
            end
            begin
                cyc(8);                        // second rise t1 = t0+8
                rd_chk("ext_cnt_t1p2", 8'h08, 32'd0);
                chk("ext_out_t1p3", 32'(tmr_out[0]), 32'd1);
                cyc(1);
                chk("ext_out_t1p4", 32'(tmr_out[0]), 32'd0);
            end
        join
        rd_chk("ext_cnt_final", 8'h08, 32'd3);

        // CNT write on a tick edge (PSC=9, tick at E+10)
        do_reset();
        apb_wr(8'h04, 32'd99);
        apb_wr(8'h00, 32'h0000_0901);
        cyc(7);
        apb_wr(8'h08, 32'd50);                 // commit at E+10
        rd_chk("sim_cnt_wr", 8'h08, 32'd50);

        // W1C of OVF on the wrap edge (LOAD=9, wrap at E+10)
        do_reset();
        apb_wr(8'h04, 32'd9);
        apb_wr(8'h00, 32'h1);
        cyc(7);
        apb_wr(8'h0C, 32'h1);                  // commit at E+10
        rd_chk("sim_w1c_set", 8'h0C, 32'h1F);
        apb_wr(8'h0C, 32'h1F);                 // commit at E+16
        rd_chk("sim_w1c_clr", 8'h0C, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
